morty_bus_arbiter: RTL and testbench
====================================

Name: morty_bus_arbiter

Overview:
- Arbitrates one Wishbone classic master bus between the fetch port (I) and the MEM-stage load/store port (D).
- Sits between the fetch/MEM stage bus requesters and the single memory bus.
- Issues one transaction at a time and forwards ack, err and read data to the granted requester.
- Fair two-way priority: D normally wins, but I cannot be starved by back-to-back D accesses.

Parameters:
- TIMEOUT_CYCLES, 255: bus cycles to wait for ack/err before a forced error. Used only with MORTY_ARB_TIMEOUT_EN.

Ports:
- clk_i  in  1  clock; all state changes on the rising edge
- rst_i  in  1  reset, synchronous, active-high
- iport_cyc_i  in  1  I request (held until ack/err)
- iport_adr_i  in  32  I address
- iport_dat_o  out  32  read data to I
- iport_ack_o  out  1  I transfer done
- iport_err_o  out  1  I bus error
- dport_cyc_i  in  1  D request (held until ack/err)
- dport_adr_i  in  32  D address
- dport_dat_i  in  32  D write data
- dport_sel_i  in  4  D byte selects
- dport_we_i  in  1  D write enable
- dport_dat_o  out  32  read data to D
- dport_ack_o  out  1  D transfer done
- dport_err_o  out  1  D bus error
- wbm_adr_o  out  32  bus address (registered)
- wbm_dat_o  out  32  bus write data (registered)
- wbm_sel_o  out  4  bus byte selects (registered)
- wbm_we_o  out  1  bus write enable (registered)
- wbm_cyc_o  out  1  bus cycle (registered)
- wbm_stb_o  out  1  bus strobe (registered)
- wbm_dat_i  in  32  bus read data
- wbm_ack_i  in  1  bus ack
- wbm_err_i  in  1  bus error

Behaviour:
- FSM states: IDLE, BUSY_I, BUSY_D.
- Reset (rst_i high at a clock edge):
  - state=IDLE, last_grant=I.
  - All wbm_* outputs are 0.
  - This also applies mid-transaction: an active bus cycle is dropped at the next edge, and no ack/err reaches any requester.
- IDLE, arbitration:
  - Only D requesting -> BUSY_D. Only I requesting -> BUSY_I.
  - Both requesting -> BUSY_I if last_grant=D, otherwise BUSY_D.
  - On every grant, last_grant is updated to the winner.
- Grant latency: a request seen in IDLE at edge N gives wbm_cyc_o=wbm_stb_o=1 from edge N, i.e. visible in cycle N+1.
  - adr/dat/sel/we are latched from the winner at that same edge and held constant while BUSY.
- I transactions: wbm_we_o=0, wbm_sel_o=4'hF, wbm_dat_o=0.
- Completion, in BUSY_x:
  - x_ack_o = wbm_ack_i and x_err_o = wbm_err_i, combinationally, only for the granted port.
  - The non-granted port sees 0.
  - On ack or err: cyc/stb are cleared at the next edge and state -> IDLE.
  - If ack and err are both high, err wins: ack is suppressed and err is reported.
- Read data: iport_dat_o and dport_dat_o are wired to wbm_dat_i at all times. They are meaningful only in the ack cycle.
- Back-to-back transactions: ack in cycle M -> IDLE in cycle M+1 -> next cyc/stb in cycle M+2. There is one mandatory idle bus cycle between transactions.
- Abort: if the granted requester drops its cyc_i while BUSY:
  - cyc/stb are cleared at the next edge and state -> IDLE.
  - An ack arriving in the abort cycle is not forwarded.
- No outputs are driven by X in any state.

Optional Feature:
- Macro: MORTY_ARB_TIMEOUT_EN.
- With the macro:
  - An 8..32-bit counter clears on grant and increments each BUSY cycle without ack/err.
  - When the counter reaches TIMEOUT_CYCLES-1, the granted port's err_o pulses for exactly one cycle.
  - In that same cycle cyc/stb are scheduled to drop and state -> IDLE.
- Without the macro: no counter, TIMEOUT_CYCLES is ignored, and the arbiter waits indefinitely for ack/err.

Test Plan:
- Reset then single D write:
  - Stimulus: dport_cyc_i=1, adr=0x100, dat=0xDEADBEEF, sel=4'hF, we=1; slave acks 2 cycles after stb.
  - Response: wbm_* carry those values one cycle after the request; dport_ack_o=1 for one cycle; iport_ack_o stays 0; cyc=0 the following cycle.
- Simultaneous I and D requests held continuously with an immediate-ack slave:
  - Response: grant order D, I, D, I.
  - Each ack is followed by one idle bus cycle.
- I read at 0x200, slave returns 0x00000013 with ack:
  - Response: iport_dat_o=0x13 and iport_ack_o=1 in the same cycle.
  - wbm_we_o=0 and wbm_sel_o=4'hF throughout.
- Slave asserts ack and err together on a D read:
  - Response: dport_err_o=1, dport_ack_o=0, FSM returns to IDLE.
- rst_i asserted while BUSY_D with no ack:
  - Response: cyc/stb are 0 after that edge.
  - A later D request wins first, since last_grant was reset to I.
- With MORTY_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=4, slave never responds:
  - Response: dport_err_o pulses 4 cycles after cyc rises, then cyc=0.
  - Without the macro, cyc stays 1 for at least 100 cycles.

Source files
------------

// File: rtl/morty_bus_arbiter_if.sv
// morty_bus_arbiter_if: fetch (I) and load/store (D) requester ports plus the
// single Wishbone classic master bus, bundled for the arbiter.
// master : arbiter view (it is the Wishbone master on the memory bus)
// slave  : environment view (requesters and memory slave)
interface morty_bus_arbiter_if;
    localparam int unsigned ADR_W = 32;
    localparam int unsigned DAT_W = 32;
    localparam int unsigned SEL_W = 4;

    // fetch port
    logic             iport_cyc_i;
    logic [ADR_W-1:0] iport_adr_i;
    logic [DAT_W-1:0] iport_dat_o;
    logic             iport_ack_o;
    logic             iport_err_o;

    // load/store port
    logic             dport_cyc_i;
    logic [ADR_W-1:0] dport_adr_i;
    logic [DAT_W-1:0] dport_dat_i;
    logic [SEL_W-1:0] dport_sel_i;
    logic             dport_we_i;
    logic [DAT_W-1:0] dport_dat_o;
    logic             dport_ack_o;
    logic             dport_err_o;

    // memory bus
    logic [ADR_W-1:0] wbm_adr_o;
    logic [DAT_W-1:0] wbm_dat_o;
    logic [SEL_W-1:0] wbm_sel_o;
    logic             wbm_we_o;
    logic             wbm_cyc_o;
    logic             wbm_stb_o;
    logic [DAT_W-1:0] wbm_dat_i;
    logic             wbm_ack_i;
    logic             wbm_err_i;

    modport master (
        input  iport_cyc_i, iport_adr_i,
        output iport_dat_o, iport_ack_o, iport_err_o,
        input  dport_cyc_i, dport_adr_i, dport_dat_i, dport_sel_i, dport_we_i,
        output dport_dat_o, dport_ack_o, dport_err_o,
        output wbm_adr_o, wbm_dat_o, wbm_sel_o, wbm_we_o, wbm_cyc_o, wbm_stb_o,
        input  wbm_dat_i, wbm_ack_i, wbm_err_i
    );

    modport slave (
        output iport_cyc_i, iport_adr_i,
        input  iport_dat_o, iport_ack_o, iport_err_o,
        output dport_cyc_i, dport_adr_i, dport_dat_i, dport_sel_i, dport_we_i,
        input  dport_dat_o, dport_ack_o, dport_err_o,
        input  wbm_adr_o, wbm_dat_o, wbm_sel_o, wbm_we_o, wbm_cyc_o, wbm_stb_o,
        output wbm_dat_i, wbm_ack_i, wbm_err_i
    );
endinterface

// File: rtl/morty_bus_arbiter.sv
// morty_bus_arbiter: shares one Wishbone classic master bus between the fetch
// port (I) and the MEM-stage load/store port (D). One transaction at a time,
// D preferred, but I wins a tie whenever D had the previous grant.
// Optional feature macro: MORTY_ARB_TIMEOUT_EN (forced error after
// TIMEOUT_CYCLES bus cycles without ack/err).
module morty_bus_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                clk_i,
    input  logic                rst_i,
    morty_bus_arbiter_if.master bus
);

    localparam int unsigned ADR_W = 32;
    localparam int unsigned DAT_W = 32;
    localparam int unsigned SEL_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_BUSY_I = 2'd1,
        ST_BUSY_D = 2'd2
    } state_t;

    state_t             r_state;
    logic               r_last_d;   // 1: previous grant went to D
    logic [ADR_W-1:0]   r_adr;
    logic [DAT_W-1:0]   r_dat;
    logic [SEL_W-1:0]   r_sel;
    logic               r_we;
    logic               r_cyc;
    logic               r_stb;

    logic               w_busy_i;
    logic               w_busy_d;
    logic               w_busy;
    logic               w_cur_cyc;
    logic               w_tmo;
    logic               w_err;
    logic               w_ack;
    logic               w_end;
    logic               w_gnt_i;
    logic               w_gnt_d;

    // Parameter sanity: the timeout compare needs TIMEOUT_CYCLES-1 >= 0
    if (TIMEOUT_CYCLES < 1) begin : g_tmo_chk
        $error("morty_bus_arbiter: TIMEOUT_CYCLES must be at least 1");
    end

    // Arbitration: lone requester wins; on a tie the port not granted last wins
    always_comb begin
        w_gnt_d = 1'b0;
        w_gnt_i = 1'b0;
        if (bus.dport_cyc_i && bus.iport_cyc_i) begin
            w_gnt_i = r_last_d;
            w_gnt_d = ~r_last_d;
        end else begin
            w_gnt_d = bus.dport_cyc_i;
            w_gnt_i = bus.iport_cyc_i;
        end
    end

    // Completion decode; reset in progress blocks any response to requesters
    always_comb begin
        w_busy_i  = (r_state == ST_BUSY_I) && !rst_i;
        w_busy_d  = (r_state == ST_BUSY_D) && !rst_i;
        w_busy    = w_busy_i || w_busy_d;
        w_cur_cyc = (w_busy_i && bus.iport_cyc_i) || (w_busy_d && bus.dport_cyc_i);
        // err (bus or timeout) dominates a simultaneous ack
        w_err     = w_cur_cyc && (bus.wbm_err_i || w_tmo);
        w_ack     = w_cur_cyc && bus.wbm_ack_i && !w_err;
        // abort (granted requester dropped cyc) also ends the bus cycle
        w_end     = w_busy && (!w_cur_cyc || bus.wbm_ack_i || bus.wbm_err_i || w_tmo);
    end

`ifdef MORTY_ARB_TIMEOUT_EN
    localparam int unsigned TMO_W_RAW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int unsigned TMO_W     = (TMO_W_RAW < 8)  ? 8  :
                                        (TMO_W_RAW > 32) ? 32 : TMO_W_RAW;

    logic [TMO_W-1:0] r_tmo_cnt;

    // Busy-cycle counter: zero while idle (so zero on grant), counts silent cycles
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_tmo_cnt <= '0;
        end else if (r_state == ST_IDLE) begin
            r_tmo_cnt <= '0;
        end else if (!bus.wbm_ack_i && !bus.wbm_err_i) begin
            r_tmo_cnt <= r_tmo_cnt + TMO_W'(1);
        end
    end

    assign w_tmo = (r_state != ST_IDLE) && !rst_i &&
                   (r_tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));
`else
    assign w_tmo = 1'b0;
`endif

    // Arbiter FSM with registered bus outputs
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state  <= ST_IDLE;
            r_last_d <= 1'b0;
            r_adr    <= '0;
            r_dat    <= '0;
            r_sel    <= '0;
            r_we     <= 1'b0;
            r_cyc    <= 1'b0;
            r_stb    <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_gnt_d) begin
                        r_state  <= ST_BUSY_D;
                        r_last_d <= 1'b1;
                        r_adr    <= bus.dport_adr_i;
                        r_dat    <= bus.dport_dat_i;
                        r_sel    <= bus.dport_sel_i;
                        r_we     <= bus.dport_we_i;
                        r_cyc    <= 1'b1;
                        r_stb    <= 1'b1;
                    end else if (w_gnt_i) begin
                        r_state  <= ST_BUSY_I;
                        r_last_d <= 1'b0;
                        r_adr    <= bus.iport_adr_i;
                        r_dat    <= '0;
                        r_sel    <= '1;
                        r_we     <= 1'b0;
                        r_cyc    <= 1'b1;
                        r_stb    <= 1'b1;
                    end
                end
                ST_BUSY_I, ST_BUSY_D: begin
                    if (w_end) begin
                        r_state <= ST_IDLE;
                        r_cyc   <= 1'b0;
                        r_stb   <= 1'b0;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_cyc   <= 1'b0;
                    r_stb   <= 1'b0;
                end
            endcase
        end
    end

    // Bus outputs and responses; read data is a straight wire to both ports
    assign bus.wbm_adr_o   = r_adr;
    assign bus.wbm_dat_o   = r_dat;
    assign bus.wbm_sel_o   = r_sel;
    assign bus.wbm_we_o    = r_we;
    assign bus.wbm_cyc_o   = r_cyc;
    assign bus.wbm_stb_o   = r_stb;

    assign bus.iport_dat_o = bus.wbm_dat_i;
    assign bus.dport_dat_o = bus.wbm_dat_i;
    assign bus.iport_ack_o = w_busy_i && w_ack;
    assign bus.iport_err_o = w_busy_i && w_err;
    assign bus.dport_ack_o = w_busy_d && w_ack;
    assign bus.dport_err_o = w_busy_d && w_err;

endmodule

// File: tb/tb_morty_bus_arbiter.sv
// tb_morty_bus_arbiter: directed steps plus a randomized phase checked against a
// transaction-level model of the arbitration rules.
module tb_morty_bus_arbiter;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    morty_bus_arbiter_if bus ();

    morty_bus_arbiter #(.TIMEOUT_CYCLES(4)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus.master)
    );

    int total = 0;
    int bad   = 0;

    // model state for the cycle-driven phases
    bit          m_last_d;
    bit          m_prev_i;
    bit          m_prev_d;
    bit          m_was_cyc;
    bit          m_done_prev;
    bit          m_cur_d;
    bit          drop_i;
    bit          drop_d;
    int          m_lat;
    logic [31:0] m_exp_adr;
    bit          gnt_q[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Cycle loop: requesters issue/hold requests, slave answers after a random
    // latency; every grant, hold, response and idle gap is checked.
    task automatic run_bus(input int ncyc, input int max_lat, input bit hold, input bit err_en);
        bit          cyc;
        bit          done;
        bit          win_d;
        bit          a;
        bit          e;
        logic [31:0] rdata;
        for (int c = 0; c < ncyc; c++) begin
            tick();
            if (drop_i) begin bus.iport_cyc_i = 1'b0; drop_i = 1'b0; end
            if (drop_d) begin bus.dport_cyc_i = 1'b0; drop_d = 1'b0; end
            bus.wbm_ack_i = 1'b0;
            bus.wbm_err_i = 1'b0;
            if (!bus.iport_cyc_i && (hold || $urandom_range(0, 3) != 0)) begin
                bus.iport_cyc_i = 1'b1;
                bus.iport_adr_i = $urandom;
            end
            if (!bus.dport_cyc_i && (hold || $urandom_range(0, 3) != 0)) begin
                bus.dport_cyc_i = 1'b1;
                bus.dport_adr_i = $urandom;
                bus.dport_dat_i = $urandom;
                bus.dport_sel_i = 4'($urandom_range(1, 15));
                bus.dport_we_i  = 1'($urandom_range(0, 1));
            end

            cyc  = bus.wbm_cyc_o;
            done = 1'b0;
            if (m_done_prev)
                chk("gap_after_done", 32'(cyc), 32'd0);
            else if (!m_was_cyc && (m_prev_i || m_prev_d))
                chk("grant_latency", 32'(cyc), 32'd1);
            else if (!m_was_cyc)
                chk("idle_no_req", 32'(cyc), 32'd0);

            if (cyc && !m_was_cyc) begin
                // winner: the lone requester, or on a tie whoever did not win last
                win_d = (m_prev_i && m_prev_d) ? !m_last_d : m_prev_d;
                m_last_d = win_d;
                m_cur_d  = win_d;
                gnt_q.push_back(win_d);
                m_lat    = $urandom_range(0, max_lat);
                if (win_d) begin
                    m_exp_adr = bus.dport_adr_i;
                    chk("d_dat", bus.wbm_dat_o, bus.dport_dat_i);
                    chk("d_sel", 32'(bus.wbm_sel_o), 32'(bus.dport_sel_i));
                    chk("d_we", 32'(bus.wbm_we_o), 32'(bus.dport_we_i));
                end else begin
                    m_exp_adr = bus.iport_adr_i;
                    chk("i_dat", bus.wbm_dat_o, 32'd0);
                    chk("i_sel", 32'(bus.wbm_sel_o), 32'hF);
                    chk("i_we", 32'(bus.wbm_we_o), 32'd0);
                end
            end

            if (cyc) begin
                chk("hold_adr", bus.wbm_adr_o, m_exp_adr);
                chk("stb", 32'(bus.wbm_stb_o), 32'd1);
                if (m_lat == 0) begin
                    rdata = $urandom;
                    e = err_en && ($urandom_range(0, 4) == 0);
                    a = !e || ($urandom_range(0, 1) == 1);
                    bus.wbm_dat_i = rdata;
                    bus.wbm_ack_i = a;
                    bus.wbm_err_i = e;
                    #1;
                    if (m_cur_d) begin
                        chk("d_resp", {30'd0, bus.dport_ack_o, bus.dport_err_o}, {30'd0, a && !e, e});
                        chk("d_other", {30'd0, bus.iport_ack_o, bus.iport_err_o}, 32'd0);
                        chk("d_rdata", bus.dport_dat_o, rdata);
                        drop_d = 1'b1;
                    end else begin
                        chk("i_resp", {30'd0, bus.iport_ack_o, bus.iport_err_o}, {30'd0, a && !e, e});
                        chk("i_other", {30'd0, bus.dport_ack_o, bus.dport_err_o}, 32'd0);
                        chk("i_rdata", bus.iport_dat_o, rdata);
                        drop_i = 1'b1;
                    end
                    done = 1'b1;
                end else begin
                    m_lat--;
                    #1;
                    chk("wait_noresp", {28'd0, bus.iport_ack_o, bus.iport_err_o,
                        bus.dport_ack_o, bus.dport_err_o}, 32'd0);
                end
            end else begin
                #1;
                chk("idle_noresp", {28'd0, bus.iport_ack_o, bus.iport_err_o,
                    bus.dport_ack_o, bus.dport_err_o}, 32'd0);
            end
            m_prev_i    = bus.iport_cyc_i;
            m_prev_d    = bus.dport_cyc_i;
            m_was_cyc   = cyc;
            m_done_prev = done;
        end
        // quiesce: withdraw every request before the next edge
        bus.iport_cyc_i = 1'b0;
        bus.dport_cyc_i = 1'b0;
        bus.wbm_ack_i   = 1'b0;
        bus.wbm_err_i   = 1'b0;
        drop_i = 1'b0;
        drop_d = 1'b0;
        tick();
        tick();
        chk("quiesce_cyc", 32'(bus.wbm_cyc_o), 32'd0);
    endtask

    initial begin
        rst = 1'b1;
        bus.iport_cyc_i = 1'b0;
        bus.iport_adr_i = '0;
        bus.dport_cyc_i = 1'b0;
        bus.dport_adr_i = '0;
        bus.dport_dat_i = '0;
        bus.dport_sel_i = '0;
        bus.dport_we_i  = 1'b0;
        bus.wbm_dat_i   = '0;
        bus.wbm_ack_i   = 1'b0;
        bus.wbm_err_i   = 1'b0;
        drop_i = 1'b0;
        drop_d = 1'b0;

        // reset values
        tick();
        tick();
        chk("rst_cyc", 32'(bus.wbm_cyc_o), 32'd0);
        chk("rst_stb", 32'(bus.wbm_stb_o), 32'd0);
        chk("rst_adr", bus.wbm_adr_o, 32'd0);
        chk("rst_dat", bus.wbm_dat_o, 32'd0);
        chk("rst_sel", 32'(bus.wbm_sel_o), 32'd0);
        chk("rst_we", 32'(bus.wbm_we_o), 32'd0);
        rst = 1'b0;

        // single D write, slave acks two cycles after stb
        bus.dport_cyc_i = 1'b1;
        bus.dport_adr_i = 32'h0000_0100;
        bus.dport_dat_i = 32'hDEAD_BEEF;
        bus.dport_sel_i = 4'hF;
        bus.dport_we_i  = 1'b1;
        tick();
        chk("dw_cyc", 32'(bus.wbm_cyc_o), 32'd1);
        chk("dw_stb", 32'(bus.wbm_stb_o), 32'd1);
        chk("dw_adr", bus.wbm_adr_o, 32'h0000_0100);
        chk("dw_dat", bus.wbm_dat_o, 32'hDEAD_BEEF);
        chk("dw_sel", 32'(bus.wbm_sel_o), 32'hF);
        chk("dw_we", 32'(bus.wbm_we_o), 32'd1);
        chk("dw_noack0", 32'(bus.dport_ack_o), 32'd0);
        tick();
        chk("dw_cyc1", 32'(bus.wbm_cyc_o), 32'd1);
        chk("dw_noack1", 32'(bus.dport_ack_o), 32'd0);
        tick();
        bus.wbm_ack_i = 1'b1;
        #1;
        chk("dw_ack", 32'(bus.dport_ack_o), 32'd1);
        chk("dw_iack", 32'(bus.iport_ack_o), 32'd0);
        chk("dw_err", 32'(bus.dport_err_o), 32'd0);
        tick();
        bus.wbm_ack_i   = 1'b0;
        bus.dport_cyc_i = 1'b0;
        chk("dw_cyc_end", 32'(bus.wbm_cyc_o), 32'd0);

        // I read at 0x200 returning 0x13
        bus.iport_cyc_i = 1'b1;
        bus.iport_adr_i = 32'h0000_0200;
        tick();
        chk("ir_cyc", 32'(bus.wbm_cyc_o), 32'd1);
        chk("ir_adr", bus.wbm_adr_o, 32'h0000_0200);
        chk("ir_we", 32'(bus.wbm_we_o), 32'd0);
        chk("ir_sel", 32'(bus.wbm_sel_o), 32'hF);
        bus.wbm_dat_i = 32'h0000_0013;
        bus.wbm_ack_i = 1'b1;
        #1;
        chk("ir_data", bus.iport_dat_o, 32'h0000_0013);
        chk("ir_ack", 32'(bus.iport_ack_o), 32'd1);
        chk("ir_dack", 32'(bus.dport_ack_o), 32'd0);
        tick();
        bus.wbm_ack_i   = 1'b0;
        bus.iport_cyc_i = 1'b0;
        chk("ir_cyc_end", 32'(bus.wbm_cyc_o), 32'd0);
        chk("ir_sel_end", 32'(bus.wbm_sel_o), 32'hF);
        chk("ir_we_end", 32'(bus.wbm_we_o), 32'd0);

        // D read with ack and err together: err wins
        bus.dport_cyc_i = 1'b1;
        bus.dport_adr_i = 32'h0000_0300;
        bus.dport_we_i  = 1'b0;
        bus.dport_sel_i = 4'h3;
        tick();
        chk("ae_cyc", 32'(bus.wbm_cyc_o), 32'd1);
        bus.wbm_ack_i = 1'b1;
        bus.wbm_err_i = 1'b1;
        #1;
        chk("ae_err", 32'(bus.dport_err_o), 32'd1);
        chk("ae_ack", 32'(bus.dport_ack_o), 32'd0);
        chk("ae_ierr", 32'(bus.iport_err_o), 32'd0);
        tick();
        bus.wbm_ack_i   = 1'b0;
        bus.wbm_err_i   = 1'b0;
        bus.dport_cyc_i = 1'b0;
        chk("ae_cyc_end", 32'(bus.wbm_cyc_o), 32'd0);
        tick();
        chk("ae_idle", 32'(bus.wbm_cyc_o), 32'd0);

        // reset while BUSY_D with no ack
        bus.dport_cyc_i = 1'b1;
        bus.dport_adr_i = 32'h0000_0400;
        bus.dport_we_i  = 1'b1;
        tick();
        chk("rb_cyc", 32'(bus.wbm_cyc_o), 32'd1);
        rst = 1'b1;
        tick();
        chk("rb_cyc_drop", 32'(bus.wbm_cyc_o), 32'd0);
        chk("rb_stb_drop", 32'(bus.wbm_stb_o), 32'd0);
        rst = 1'b0;

        // both held, immediate ack: first grant D (last grant reset to I), then alternate
        bus.iport_cyc_i = 1'b1;
        bus.iport_adr_i = 32'h0000_0500;
        m_last_d    = 1'b0;
        m_prev_i    = 1'b1;
        m_prev_d    = 1'b1;
        m_was_cyc   = 1'b0;
        m_done_prev = 1'b0;
        gnt_q.delete();
        run_bus(12, 0, 1'b1, 1'b0);
        chk("fair_count", 32'(gnt_q.size() >= 4), 32'd1);
        if (gnt_q.size() >= 4) begin
            chk("fair_0_d", 32'(gnt_q[0]), 32'd1);
            chk("fair_1_i", 32'(gnt_q[1]), 32'd0);
            chk("fair_2_d", 32'(gnt_q[2]), 32'd1);
            chk("fair_3_i", 32'(gnt_q[3]), 32'd0);
        end

        // randomized traffic with variable latency and errors
        m_prev_i    = 1'b0;
        m_prev_d    = 1'b0;
        m_was_cyc   = 1'b0;
        m_done_prev = 1'b0;
        run_bus(400, 3, 1'b0, 1'b1);

        // silent slave
        bus.dport_cyc_i = 1'b1;
        bus.dport_adr_i = 32'h0000_0600;
        bus.dport_we_i  = 1'b0;
        tick();
        chk("to_cyc", 32'(bus.wbm_cyc_o), 32'd1);
`ifdef MORTY_ARB_TIMEOUT_EN
        for (int k = 1; k <= 4; k++) begin
            if (k > 1) tick();
            chk("to_err", 32'(bus.dport_err_o), (k == 4) ? 32'd1 : 32'd0);
            chk("to_ack", 32'(bus.dport_ack_o), 32'd0);
        end
        tick();
        bus.dport_cyc_i = 1'b0;
        chk("to_cyc_end", 32'(bus.wbm_cyc_o), 32'd0);
        chk("to_err_end", 32'(bus.dport_err_o), 32'd0);
`else
        for (int k = 0; k < 100; k++) begin
            tick();
            chk("nto_cyc", 32'(bus.wbm_cyc_o), 32'd1);
            chk("nto_err", 32'(bus.dport_err_o), 32'd0);
        end
        // abort: requester withdraws; an ack in that cycle is not forwarded
        bus.dport_cyc_i = 1'b0;
        bus.wbm_ack_i   = 1'b1;
        #1;
        chk("abort_ack", 32'(bus.dport_ack_o), 32'd0);
        tick();
        bus.wbm_ack_i = 1'b0;
        chk("abort_cyc", 32'(bus.wbm_cyc_o), 32'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
